// File: rtl/ec_point_stream_tx_pkg.sv
// ----------------------------------------------------------------------------
// ec_point_stream_tx_pkg
//   Shared constants, types and sizing helpers for the wide-to-narrow
//   elliptic-curve point serializer and its host-side receiver.
//   - FP2_JB_POINT_BITS : width of one FP2 Jacobian point result word.
//   - ser_state_e       : serializer FSM states.
//   - ser_beats()       : number of narrow beats needed for one wide word.
//   - cnt_bits()        : counter/index width that is never zero.
// ----------------------------------------------------------------------------
package ec_point_stream_tx_pkg;

  localparam int FP2_JB_POINT_BITS = 2286;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Beats of out_byts bytes needed to carry in_bits bits, byte-rounded first.
  // ser_beats(bits, 1) therefore gives the byte count of the word.
  function automatic int ser_beats(input int in_bits, input int out_byts);
    int in_byts;
    in_byts = (in_bits + 7) / 8;
    return (in_byts + out_byts - 1) / out_byts;
  endfunction

  // Width able to index n items; kept at least 1 so n == 1 stays legal.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ec_point_stream_tx_if.sv
// ----------------------------------------------------------------------------
// if_axi_stream
//   Packet stream bundle with valid/ready handshake.
//   val/rdy : handshake, transfer when both are high on a rising clock edge
//   sop/eop : first/last beat of a packet
//   mod     : valid bytes on the eop beat, 0 meaning all DAT_BYTS bytes
//   err     : packet error flag
//   ctl     : sideband field carried with the data
//   dat     : payload, byte 0 in the least significant byte
//   Modports: source drives everything but rdy, sink drives only rdy.
// ----------------------------------------------------------------------------
interface if_axi_stream
  import ec_point_stream_tx_pkg::*;
#(
  parameter int DAT_BYTS = 8,
  parameter int DAT_BITS = DAT_BYTS * 8,
  parameter int CTL_BITS = 16,
  parameter int MOD_BITS = cnt_bits(DAT_BYTS)
);

  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [MOD_BITS-1:0] mod;
  logic [CTL_BITS-1:0] ctl;
  logic [DAT_BITS-1:0] dat;

  modport source (output val, sop, eop, err, mod, ctl, dat, input rdy);
  modport sink   (input val, sop, eop, err, mod, ctl, dat, output rdy);

endinterface

// File: rtl/ec_point_stream_tx.sv
// ----------------------------------------------------------------------------
// ec_point_stream_tx
//   Serializes one wide single-beat EC result word into a packet of narrow
//   stream beats, byte 0 of the word on beat 0 (LSB first).
//
//   Ports:
//     i_clk   : clock
//     i_rst_n : asynchronous active-low reset; drops a packet in flight
//     i_axi   : wide input (sink), one beat per word; sop/eop/mod ignored
//     o_axi   : narrow output packet (source), ctl/err repeated on each beat
//
//   Build option: EC_SER_DROP_ERR_EN
//     defined   - words arriving with err=1 are accepted and discarded, and
//                 counted in the saturating debug counter drop_cnt_q.
//     undefined - such words are serialized with err=1 on every beat.
//
//   All outputs are registered. i_axi.rdy is combinational: high in IDLE,
//   and on the eop beat while o_axi.rdy is high, so back-to-back words
//   stream without an idle cycle between packets.
// ----------------------------------------------------------------------------
module ec_point_stream_tx
  import ec_point_stream_tx_pkg::*;
#(
  parameter int IN_BITS  = FP2_JB_POINT_BITS,
  parameter int OUT_BYTS = 8,
  parameter int CTL_BITS = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  if_axi_stream.sink    i_axi,
  if_axi_stream.source  o_axi
);

  localparam int IN_BYTS   = ser_beats(IN_BITS, 1);
  localparam int NUM_BEATS = ser_beats(IN_BITS, OUT_BYTS);
  localparam int LAST_MOD  = IN_BYTS % OUT_BYTS;
  localparam int OUT_BITS  = OUT_BYTS * 8;
  localparam int WORD_BITS = NUM_BEATS * OUT_BITS;
  localparam int CNT_BITS  = cnt_bits(NUM_BEATS);
  localparam int MOD_BITS  = cnt_bits(OUT_BYTS);

  localparam logic [CNT_BITS-1:0] LAST_BEAT  = CNT_BITS'(NUM_BEATS - 1);
  localparam logic [MOD_BITS-1:0] LAST_MOD_V = MOD_BITS'(LAST_MOD);
  localparam logic                ONE_BEAT   = (NUM_BEATS == 1);

  // Latched word viewed as an array of output beats: indexing it by beat
  // number is the byte-aligned output mux.
  typedef logic [NUM_BEATS-1:0][OUT_BITS-1:0] word_t;

  ser_state_e          state_q, state_d;
  logic [CNT_BITS-1:0] beat_cnt_q, beat_cnt_d;
  word_t               word_q, word_d, word_in;
  logic                val_q, val_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic                err_q, err_d;
  logic [MOD_BITS-1:0] mod_q, mod_d;
  logic [CTL_BITS-1:0] ctl_q, ctl_d;
  logic [OUT_BITS-1:0] dat_q, dat_d;

  logic in_rdy;
  logic accept;
  logic drop;
  logic load_word;
  logic advance;

  // Ready is forced low while reset is asserted so no word is taken then.
  assign in_rdy = i_rst_n & ((state_q == ST_IDLE) |
                             ((state_q == ST_SEND) & eop_q & o_axi.rdy));
  assign accept = i_axi.val & in_rdy;

`ifdef EC_SER_DROP_ERR_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign drop = accept & i_axi.err;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end
`else
  assign drop = 1'b0;
`endif

  assign load_word = accept & ~drop;
  // Non-eop beat taken by the sink: move on to the next beat.
  assign advance   = (state_q == ST_SEND) & o_axi.rdy & ~eop_q;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so nothing is left unassigned on any path (no latches).
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    val_d      = val_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    err_d      = err_q;
    mod_d      = mod_q;
    ctl_d      = ctl_q;
    dat_d      = dat_q;
    word_in    = WORD_BITS'(i_axi.dat);
    word_d     = load_word ? word_in : word_q;

    case (state_q)
      ST_IDLE: begin
        if (load_word) state_d = ST_SEND;
      end
      ST_SEND: begin
        // eop beat taken without a follow-on word: packet done.
        if (o_axi.rdy && eop_q && !load_word) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_word) begin
      beat_cnt_d = '0;
      val_d      = 1'b1;
      sop_d      = 1'b1;
      eop_d      = ONE_BEAT;
      mod_d      = ONE_BEAT ? LAST_MOD_V : '0;
      ctl_d      = i_axi.ctl;
      err_d      = i_axi.err;
    end else if (advance) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
      sop_d      = 1'b0;
      eop_d      = (beat_cnt_d == LAST_BEAT);
      mod_d      = eop_d ? LAST_MOD_V : '0;
    end else if (state_d == ST_IDLE) begin
      val_d = 1'b0;
      sop_d = 1'b0;
      eop_d = 1'b0;
      mod_d = '0;
    end

    // The output register reloads only when a new beat is presented, which
    // keeps every output frozen while the sink stalls.
    if (load_word || advance) dat_d = word_d[beat_cnt_d];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      val_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
      mod_q      <= '0;
      ctl_q      <= '0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      val_q      <= val_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      err_q      <= err_d;
      mod_q      <= mod_d;
      ctl_q      <= ctl_d;
      dat_q      <= dat_d;
    end
  end

  // NOTE: the wide word store has no reset; it is only read after a load,
  // and leaving it out of reset keeps thousands of flops off the reset tree.
  always_ff @(posedge i_clk) begin
    word_q <= word_d;
  end

  assign i_axi.rdy = in_rdy;
  assign o_axi.val = val_q;
  assign o_axi.sop = sop_q;
  assign o_axi.eop = eop_q;
  assign o_axi.err = err_q;
  assign o_axi.mod = mod_q;
  assign o_axi.ctl = ctl_q;
  assign o_axi.dat = dat_q;

endmodule
